// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer
//
// Runs one M-extension operation at a time: a shift-add multiply or a
// restoring divide over WIDTH iterations on operand magnitudes, with the
// sign fixed up at the end.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only in IDLE
//   op       funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b     rs1 / rs2 operands, sampled with start
//   kill     abort the operation in flight (flush/trap)
//   busy     stall request, high whenever not IDLE
//   done     one-cycle pulse, result valid this cycle
//   result   registered result, held until replaced by a later operation

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t state, state_nx;

    // acc holds {product high, multiplier/product low} for multiply and
    // {remainder, quotient} for divide. Until PREP it holds the raw a operand.
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   bval;   // raw b until PREP, then multiplicand/divisor magnitude
    logic [CW-1:0]      cnt;
    logic               neg_q;  // sign of product or quotient
    logic               neg_r;  // sign of remainder

    logic               is_div, signed_a, signed_b, sa, sb;
    logic [WIDTH-1:0]   a_raw, a_mag, b_mag;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic               ge;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_f, rem_f, fix_res;

    always_comb begin
        is_div   = op_q[2];
        // Signed a: MUL, MULH, MULHSU, DIV, REM. Signed b: MUL, MULH, DIV, REM.
        signed_a = op_q[2] ? !op_q[0] : (op_q[1:0] != 2'b11);
        signed_b = op_q[2] ? !op_q[0] : !op_q[1];
        a_raw    = acc[WIDTH-1:0];
        sa       = signed_a & a_raw[WIDTH-1];
        sb       = signed_b & bval[WIDTH-1];
        a_mag    = sa ? -a_raw : a_raw;
        b_mag    = sb ? -bval  : bval;

        div_zero = is_div && (bval == '0);
        div_ovf  = is_div && !op_q[0] && (a_raw == SMIN) && (bval == '1);
        if (div_zero)
            special_res = op_q[1] ? a_raw : '1;
        else
            special_res = op_q[1] ? '0 : SMIN;

        // Shift-add step: the add can carry out, so the carry becomes the
        // new top bit after the right shift.
        mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bval})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring step: the shifted remainder needs one extra bit before
        // the trial subtract; a kept difference always fits in WIDTH bits.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        ge       = rem_sh >= {1'b0, bval};
        div_next = ge ? {rem_sh[WIDTH-1:0] - bval, acc[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0],        acc[WIDTH-2:0], 1'b0};

        prod_f = neg_q ? -acc : acc;
        quo_f  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_f  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (is_div)
            fix_res = op_q[1] ? rem_f : quo_f;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod_f[WIDTH-1:0] : prod_f[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && !kill) state_nx = S_PREP;
            S_PREP: begin
                if (kill)                     state_nx = S_IDLE;
                else if (div_zero || div_ovf) state_nx = S_DONE;
                else                          state_nx = S_RUN;
            end
            S_RUN: begin
                if (kill)                              state_nx = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))        state_nx = S_FIX;
            end
            S_FIX:  state_nx = kill ? S_IDLE : S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            acc    <= '0;
            bval   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q <= op;
                        acc  <= {{WIDTH{1'b0}}, a};
                        bval <= b;
                    end
                end
                S_PREP: begin
                    if (!kill) begin
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            bval  <= b_mag;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            cnt   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!kill)
                        result <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq

module tb_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp = 32'h0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        longint unsigned pu;
        logic [63:0] w;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        case (o)
            3'd0: begin p = sx * sy; w = p; return w[31:0]; end
            3'd1: begin p = sx * sy; w = p; return w[63:32]; end
            3'd2: begin p = sx * uy; w = p; return w[63:32]; end
            3'd3: begin pu = longint'(ux) * longint'(uy); w = pu; return w[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                p = sx / sy; w = p; return w[31:0];
            end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                p = sx % sy; w = p; return w[31:0];
            end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one operation from IDLE, wait (bounded) for done, check latency,
    // result and the return to IDLE.
    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input int el);
        int lat;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(el));
        chk({nm, " result"}, result, er);
        @(posedge clk); #1;
        chk({nm, " done low"}, {31'b0, done}, 32'd0);
        last_exp = er;
    endtask

    vec_t tbl[16];

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          sel, lat;
        bit          seen;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        tbl[1]  = '{3'd1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 34};
        tbl[2]  = '{3'd3, 32'd7,          32'hFFFFFFFD, 32'h00000006, 34};
        tbl[3]  = '{3'd4, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 34};
        tbl[4]  = '{3'd6, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 34};
        tbl[5]  = '{3'd5, 32'd20,         32'd6,        32'd3,        34};
        tbl[6]  = '{3'd7, 32'd20,         32'd6,        32'd2,        34};
        tbl[7]  = '{3'd4, 32'h12345678,   32'd0,        32'hFFFFFFFF, 1};
        tbl[8]  = '{3'd7, 32'h12345678,   32'd0,        32'h12345678, 1};
        tbl[9]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        tbl[10] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};
        tbl[11] = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        tbl[12] = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        tbl[13] = '{3'd5, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 34};
        tbl[14] = '{3'd6, 32'hABCDEF01,   32'd0,        32'hABCDEF01, 1};
        tbl[15] = '{3'd5, 32'h00000001,   32'd0,        32'hFFFFFFFF, 1};

        reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

        for (int i = 0; i < 48; i++) begin
            ro  = 3'($urandom_range(0, 7));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) ry = 32'd0;
            else if (sel == 1) ry = 32'($urandom_range(1, 15));
            else if (sel == 2) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            do_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry, ref_res(ro, rx, ry), ref_lat(ro, rx, ry));
        end

        // Kill a multiply at cycle 10: no done, result untouched.
        start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("kill no done", {31'b0, seen}, 32'd0);
        chk("kill result held", result, last_exp);

        // Start pulsed while busy must be ignored.
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy start latency", 32'(lat), 32'd34);
        chk("busy start result", result, 32'd142);
        // Start seen in DONE is ignored.
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done start ignored", {31'b0, busy}, 32'd0);
        // First IDLE after DONE accepts a start.
        do_op("after done", 3'd0, 32'd5, 32'd5, 32'd25, 34);

        // Kill in IDLE blocks a simultaneous start.
        start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("idle kill blocks", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = 3'd4; a = 32'hFFFFFFEC; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        #1 reset_n = 1'b0;
        #1;
        chk("mid reset busy",   {31'b0, busy}, 32'd0);
        chk("mid reset done",   {31'b0, done}, 32'd0);
        chk("mid reset result", result, 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        do_op("post reset div", 3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
